// File: rtl/irq_ctrl.sv
// Latched, maskable interrupt controller between peripheral IRQ lines and the host irq/fiq pins.
// Optional event counter at address 4 is built when IRQ_EVENT_COUNTER_EN is defined.
module irq_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        econet_fiq,
    input  logic        ethernet_irq,
    input  logic        ide_irq,
    input  logic        uart_tx_irq,
    input  logic        uart_rx_irq,
    inout  wire  [7:0]  D,
    input  logic [13:0] A,
    input  logic        cs,
    input  logic        re,
    input  logic        we,
    output logic        irq,
    output logic        fiq
);

    localparam int NSYNC = 6;
    localparam int IDX_ECONET = 4;
    localparam int IDX_WR = 5;

    // Synchroniser lanes: [3:0] = {eth, ide, tx, rx} in pending-bit order, then econet, then bus write strobe.
    logic [NSYNC-1:0]       raw_in;
    logic [SYNC_STAGES-1:0] sync_q [NSYNC];
    logic [NSYNC-1:0]       sync_o;

    logic [3:0] src_hist_q;
    logic       wr_hist_q;
    logic [3:0] src_rise;
    logic       wr_stb;
    logic [2:0] addr;

    logic [3:0] pend_q;
    logic [3:0] mask_q;
    logic [1:0] ctrl_q;
    logic       irq_q;
    logic       fiq_q;
    logic [3:0] w1c;
    logic [7:0] rdata;
    logic [7:0] cnt_rd;
    logic       unused_bits;

    assign raw_in = {cs & we, econet_fiq, ethernet_irq, ide_irq, uart_tx_irq, uart_rx_irq};

    always_comb begin
        sync_o = '0;
        for (int i = 0; i < NSYNC; i++) begin
            sync_o[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    assign src_rise = sync_o[3:0] & ~src_hist_q;
    assign wr_stb   = sync_o[IDX_WR] & ~wr_hist_q;
    assign addr     = A[2:0];
    assign w1c      = (wr_stb && addr == 3'd0) ? D[6:3] : 4'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSYNC; i++) begin
                sync_q[i] <= '0;
            end
            src_hist_q <= '0;
            wr_hist_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NSYNC; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
            end
            src_hist_q <= sync_o[3:0];
            wr_hist_q  <= sync_o[IDX_WR];
        end
    end

    // A new edge overrides a same-cycle clear so no event is ever dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            mask_q <= '0;
            ctrl_q <= '0;
            irq_q  <= 1'b0;
            fiq_q  <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~w1c) | src_rise;
            if (wr_stb && addr == 3'd1) begin
                mask_q <= D[6:3];
            end
            if (wr_stb && addr == 3'd2) begin
                ctrl_q <= D[1:0];
            end
            irq_q <= ctrl_q[0] && |(pend_q & mask_q);
            fiq_q <= ctrl_q[1] && sync_o[IDX_ECONET];
        end
    end

`ifdef IRQ_EVENT_COUNTER_EN
    logic [7:0] cnt_q;
    logic       new_evt;
    logic       cnt_clr;

    assign new_evt = |(src_rise & ~pend_q);
    assign cnt_clr = wr_stb && addr == 3'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
        end else if (cnt_clr) begin
            cnt_q <= new_evt ? 8'h01 : 8'h00;
        end else if (new_evt && cnt_q != 8'hff) begin
            cnt_q <= cnt_q + 8'h01;
        end
    end

    assign cnt_rd = cnt_q;
`else
    assign cnt_rd = 8'h00;
`endif

    always_comb begin
        rdata = 8'h00;
        case (addr)
            3'd0:    rdata = {sync_o[IDX_ECONET], pend_q, 1'b0, fiq_q, irq_q};
            3'd1:    rdata = {1'b0, mask_q, 3'b000};
            3'd2:    rdata = {6'b000000, ctrl_q};
            3'd3:    rdata = {sync_o[IDX_ECONET], sync_o[3:0], 3'b000};
            3'd4:    rdata = cnt_rd;
            default: rdata = 8'h00;
        endcase
    end

    assign D   = (cs && re) ? rdata : 8'hzz;
    assign irq = irq_q;
    assign fiq = fiq_q;

    assign unused_bits = &{1'b0, A[13:3], D[7], D[2]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: bus reads are scored against an expected queue.
module tb_irq_ctrl;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        econet_fiq = 1'b0;
    logic        ethernet_irq = 1'b0;
    logic        ide_irq = 1'b0;
    logic        uart_tx_irq = 1'b0;
    logic        uart_rx_irq = 1'b0;
    logic [13:0] A = '0;
    logic        cs = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic        irq;
    logic        fiq;
    logic [7:0]  tb_d = '0;
    logic        tb_oe = 1'b0;
    wire  [7:0]  D;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    assign D = tb_oe ? tb_d : 8'hzz;

    irq_ctrl #(.SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .econet_fiq(econet_fiq), .ethernet_irq(ethernet_irq),
        .ide_irq(ide_irq), .uart_tx_irq(uart_tx_irq), .uart_rx_irq(uart_rx_irq),
        .D(D), .A(A), .cs(cs), .re(re), .we(we), .irq(irq), .fiq(fiq)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Immediate read from the current time; expected value queued before the strobe.
    task automatic peek(input logic [2:0] a, input logic [7:0] e, input string tag);
        logic [7:0] got;
        A[2:0] = a;
        A[13:3] = 11'($urandom_range(0, 2047));
        exp_q.push_back(e);
        cs = 1'b1;
        re = 1'b1;
        #1;
        got = D;
        cs = 1'b0;
        re = 1'b0;
        check(tag, got, exp_q.pop_front());
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string tag);
        @(negedge clk);
        peek(a, e, tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, input bit raise_rx);
        @(negedge clk);
        A[2:0] = a;
        A[13:3] = 11'($urandom_range(0, 2047));
        tb_d = d;
        tb_oe = 1'b1;
        cs = 1'b1;
        we = 1'b1;
        if (raise_rx) uart_rx_irq = 1'b1;
        repeat (SS + 2) @(negedge clk);
        cs = 1'b0;
        we = 1'b0;
        tb_oe = 1'b0;
        repeat (SS + 3) @(negedge clk);
    endtask

    task automatic settle();
        repeat (SS + 4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check("irq_in_reset", 8'(irq), 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("irq_after_reset", 8'(irq), 8'h00);
        check("fiq_after_reset", 8'(fiq), 8'h00);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 8'h00, $sformatf("reset_rd_a%0d", i));
        end

        // Register field widths
        wr(3'd1, 8'hff, 1'b0);
        rd(3'd1, 8'h78, "mask_width");
        wr(3'd2, 8'hff, 1'b0);
        rd(3'd2, 8'h03, "ctrl_width");
        wr(3'd5, 8'hff, 1'b0);
        rd(3'd5, 8'h00, "addr5_ignored");

        // Ethernet edge latency and W1C
        wr(3'd1, 8'h40, 1'b0);
        wr(3'd2, 8'h01, 1'b0);
        rd(3'd1, 8'h40, "mask_rb");
        rd(3'd2, 8'h01, "ctrl_rb");
        @(negedge clk);
        ethernet_irq = 1'b1;
        repeat (SS + 1) @(posedge clk);
        #1 check("eth_irq_not_yet", 8'(irq), 8'h00);
        peek(3'd0, 8'h40, "eth_pending_latency");
        @(posedge clk);
        #1 check("eth_irq_latency", 8'(irq), 8'h01);
        repeat (96) @(negedge clk);
        ethernet_irq = 1'b0;
        rd(3'd0, 8'h41, "eth_status");
        wr(3'd0, 8'h40, 1'b0);
        rd(3'd0, 8'h00, "eth_w1c_status");
        check("eth_w1c_irq", 8'(irq), 8'h00);

        // Level-held IDE: no re-latch after clear
        wr(3'd1, 8'h00, 1'b0);
        @(negedge clk);
        ide_irq = 1'b1;
        settle();
        rd(3'd0, 8'h20, "ide_masked_status");
        check("ide_masked_irq", 8'(irq), 8'h00);
        wr(3'd1, 8'h20, 1'b0);
        check("ide_unmasked_irq", 8'(irq), 8'h01);
        wr(3'd0, 8'h20, 1'b0);
        rd(3'd0, 8'h00, "ide_w1c_status");
        repeat (10) @(negedge clk);
        rd(3'd0, 8'h00, "ide_no_relatch");
        check("ide_no_relatch_irq", 8'(irq), 8'h00);
        ide_irq = 1'b0;
        settle();

        // Econet FIQ gating and RAW register
        wr(3'd2, 8'h00, 1'b0);
        @(negedge clk);
        econet_fiq = 1'b1;
        ethernet_irq = 1'b1;
        uart_tx_irq = 1'b1;
        settle();
        check("fiq_gated", 8'(fiq), 8'h00);
        rd(3'd3, 8'hd0, "raw_read");
        ethernet_irq = 1'b0;
        uart_tx_irq = 1'b0;
        wr(3'd0, 8'h78, 1'b0);
        rd(3'd0, 8'h80, "econet_status");
        wr(3'd2, 8'h02, 1'b0);
        check("fiq_enabled", 8'(fiq), 8'h01);
        rd(3'd0, 8'h82, "econet_fiq_status");
        @(negedge clk);
        econet_fiq = 1'b0;
        repeat (SS) @(posedge clk);
        #1 check("fiq_hold", 8'(fiq), 8'h01);
        @(posedge clk);
        #1 check("fiq_drop", 8'(fiq), 8'h00);

        // UART rx edge coinciding with W1C: set wins
        wr(3'd2, 8'h00, 1'b0);
        @(negedge clk);
        uart_rx_irq = 1'b1;
        settle();
        uart_rx_irq = 1'b0;
        settle();
        rd(3'd0, 8'h08, "rx_set");
        wr(3'd0, 8'h08, 1'b1);
        rd(3'd0, 8'h08, "rx_set_wins");
        wr(3'd0, 8'h08, 1'b0);
        rd(3'd0, 8'h00, "rx_w1c");
        uart_rx_irq = 1'b0;
        settle();

`ifdef IRQ_EVENT_COUNTER_EN
        wr(3'd4, 8'h00, 1'b0);
        rd(3'd4, 8'h00, "cnt_clear");
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            ethernet_irq = 1'b1;
            repeat (3) @(negedge clk);
            ethernet_irq = 1'b0;
            repeat (3) @(negedge clk);
            wr(3'd0, 8'h40, 1'b0);
            if (n == 0) rd(3'd4, 8'h01, "cnt_one");
        end
        rd(3'd4, 8'hff, "cnt_saturate");
        wr(3'd4, 8'h5a, 1'b0);
        rd(3'd4, 8'h00, "cnt_write_clear");
`else
        @(negedge clk);
        ethernet_irq = 1'b1;
        settle();
        ethernet_irq = 1'b0;
        wr(3'd4, 8'h5a, 1'b0);
        rd(3'd4, 8'h00, "addr4_no_counter");
        wr(3'd0, 8'h40, 1'b0);
`endif

        // Asynchronous reset mid-cycle with irq asserted
        wr(3'd1, 8'h40, 1'b0);
        wr(3'd2, 8'h01, 1'b0);
        @(negedge clk);
        ethernet_irq = 1'b1;
        settle();
        ethernet_irq = 1'b0;
        check("pre_reset_irq", 8'(irq), 8'h01);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset_irq", 8'(irq), 8'h00);
        peek(3'd0, 8'h00, "reset_status");
        peek(3'd1, 8'h00, "reset_mask");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        settle();
        rd(3'd2, 8'h00, "post_reset_ctrl");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Latched, maskable interrupt controller. It is the host-write side of the interrupt status port: it captures edges from the Ethernet, IDE and UART sources and holds them as pending bits. The host masks pending bits, enables outputs and clears pending bits through the same 8-bit peripheral bus (D/A/cs/re/we). Econet FIQ stays a level path but can be gated. Sits between the peripheral IRQ lines and the host irq/fiq pins.

Parameters:
SYNC_STAGES, 2, flops in each input synchroniser (sources and bus strobes); legal range 2..3.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
econet_fiq  input  1  Econet FIQ request, level, asynchronous
ethernet_irq  input  1  Ethernet request, asynchronous
ide_irq  input  1  IDE request, asynchronous
uart_tx_irq  input  1  UART transmit request, asynchronous
uart_rx_irq  input  1  UART receive request, asynchronous
D  inout  8  host data bus; driven only while cs && re
A  input  14  host address; only A[2:0] decoded
cs  input  1  chip select, active high, asynchronous to clk
re  input  1  read strobe, active high
we  input  1  write strobe, active high
irq  output  1  registered host IRQ
fiq  output  1  registered host FIQ

Behaviour:
- Reset (rst_n low, async): pending[3:0]=0, mask=0x00, ctrl=0x00, irq=0, fiq=0, all synchronisers 0. D tristated.
- Source path: each of ethernet/ide/uart_tx/uart_rx passes through SYNC_STAGES flops plus one history flop. A synchronised rising edge sets its pending bit. Level-held sources do not re-set a bit after it is cleared.
- Pending bit positions, shared by all registers: [6]=ethernet, [5]=ide, [4]=uart_tx, [3]=uart_rx.
- Write path: cs&&we is synchronised (SYNC_STAGES). wr_stb is a one-cycle pulse on its synchronised rising edge. On wr_stb, D and A[2:0] are sampled. The host holds D/A stable and the strobe high for at least SYNC_STAGES+1 clk periods. One wr_stb per strobe, however long the strobe is.
- Address map, A[2:0]:
  - 0 STATUS, read: {econet_sync, pending[6:3], 0, fiq, irq}. Write: 1 in bits [6:3] clears that pending bit; other bits ignored.
  - 1 MASK, R/W: bits [6:3] are valid; all other bits read 0.
  - 2 CTRL, R/W: bit0 = IRQ enable, bit1 = FIQ enable, bits [7:2] read 0.
  - 3 RAW, read-only: {econet_sync, eth_sync, ide_sync, tx_sync, rx_sync, 000}.
  - 4: see optional feature.
  - 5-7: read 0x00; writes ignored.
- Reads are combinational from current register state while cs&&re. When cs&&we&&re are all asserted, the read still drives D.
- Simultaneous source edge and W1C on the same bit in the same cycle: set wins, and the bit stays 1.
- irq register next = ctrl[0] && |(pending & mask). fiq register next = ctrl[1] && econet_sync. Both update every clk.
- Latency: a source edge reaches pending after SYNC_STAGES+1 clk edges, and irq follows 1 edge later. A W1C or mask write takes effect on irq 1 edge after wr_stb.
- Reset mid-strobe: the strobe is lost. If cs&&we is still high once rst_n releases, the synchroniser sees a rising edge and the write completes.

Optional Feature:
- Macro: IRQ_EVENT_COUNTER_EN.
- With the macro: an 8-bit saturating counter increments on every cycle in which at least one pending bit goes 0->1. It increments by 1 per cycle, regardless of how many bits set. It holds at 0xFF. Address 4 reads the counter; any write to address 4 clears it to 0x00. If a clear and an increment happen in the same cycle, the result is 0x01. Reset value is 0x00.
- Without the macro: address 4 reads 0x00, writes are ignored, and there is no counter logic.

Test Plan:
- Reset, then read addresses 0-3 -> 0x00 each (sources low); irq=0, fiq=0.
- MASK=0x40, CTRL=0x01, pulse ethernet_irq for 1 us -> STATUS bit6=1, irq=1 within SYNC_STAGES+2 clks. Write 0x40 to addr 0 -> STATUS=0x00 and irq=0 one clk after wr_stb.
- ide_irq held high, MASK=0x00 -> STATUS=0x20 and irq=0. Write MASK=0x20 -> irq=1. W1C 0x20 with ide_irq still high -> bit5 stays 0 (no re-latch).
- econet_fiq high with CTRL=0x00 -> fiq=0 and STATUS bit7=1. CTRL=0x02 -> fiq=1. Drop econet_fiq -> fiq=0 after SYNC_STAGES+1 clks.
- uart_rx edge in the same cycle as a W1C 0x08 wr_stb -> bit3 remains 1.
- With IRQ_EVENT_COUNTER_EN: 300 ethernet edges -> addr 4 reads 0xFF. Write addr 4 -> reads 0x00. Without the macro -> addr 4 always reads 0x00.
